// File: rtl/life_pkg.sv
// Shared constants and FSM encoding for the generation line buffer.
package life_pkg;

    localparam int ROW_LENGTH = 1280;
    localparam int NUM_ROWS   = 720;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } lb_state_t;

endpackage

// File: rtl/row_window_shift.sv
// Three-row sliding window (top/middle/bottom) fed from the bottom.
// shift_en loads din into bottom, shift_zero loads zero (dead border below
// the last row). clear empties the window before a new pass.
module row_window_shift #(
    parameter int ROW_LENGTH = life_pkg::ROW_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  shift_zero,
    input  logic [ROW_LENGTH-1:0] din,
    output logic [ROW_LENGTH-1:0] top_row,
    output logic [ROW_LENGTH-1:0] middle_row,
    output logic [ROW_LENGTH-1:0] bottom_row
);

    logic [ROW_LENGTH-1:0] top_reg;
    logic [ROW_LENGTH-1:0] middle_reg;
    logic [ROW_LENGTH-1:0] bottom_reg;

    // Window registers: clear has priority, then a data or zero shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg    <= '0;
            middle_reg <= '0;
            bottom_reg <= '0;
        end else if (clear) begin
            top_reg    <= '0;
            middle_reg <= '0;
            bottom_reg <= '0;
        end else if (shift_en || shift_zero) begin
            top_reg    <= middle_reg;
            middle_reg <= bottom_reg;
            bottom_reg <= shift_en ? din : '0;
        end
    end

    assign top_row    = top_reg;
    assign middle_row = middle_reg;
    assign bottom_row = bottom_reg;

endmodule

// File: rtl/line_buffer.sv
// Reads one generation row by row from BRAM and presents one complete
// three-row window per cycle to the next-state stage.
module line_buffer #(
    parameter int ROW_LENGTH = life_pkg::ROW_LENGTH,
    parameter int NUM_ROWS   = life_pkg::NUM_ROWS,
    parameter int ADDR_WIDTH = life_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ROW_LENGTH-1:0] rd_data,
    output logic [ROW_LENGTH-1:0] top_row,
    output logic [ROW_LENGTH-1:0] middle_row,
    output logic [ROW_LENGTH-1:0] bottom_row,
    output logic [ADDR_WIDTH-1:0] calc_row_in,
    output logic                  calc_flg,
    output logic                  valid_set,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           gen_count
);

    import life_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

    lb_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] rd_cnt_reg;
    logic [1:0]            flush_cnt_reg;
    logic                  rd_valid_reg;
    logic                  primed_reg;
    logic                  valid_set_reg;
    logic [ADDR_WIDTH-1:0] calc_row_reg;
    logic                  busy_reg;
    logic                  calc_flg_reg;
    logic                  done_reg;
    logic [15:0]           gen_count_reg;

    logic start_pass;
    logic enter_done;
    logic shift_en;
    logic shift_zero;

    // FLUSH cycle 0 absorbs the last read data, cycle 1 performs the zero
    // shift, cycle 2 is when the final window is on display.
    assign start_pass = (state_reg == IDLE) && start;
    assign enter_done = (state_reg == FLUSH) && (flush_cnt_reg == 2'd2);
    assign shift_en   = rd_valid_reg;
    assign shift_zero = (state_reg == FLUSH) && (flush_cnt_reg == 2'd1);

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = READ;
            READ:    if (rd_cnt_reg == LAST_ROW) state_next = FLUSH;
            FLUSH:   if (flush_cnt_reg == 2'd2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Read address counter, flush sub-counter and read-data-valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_reg    <= '0;
            flush_cnt_reg <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            if (start_pass)              rd_cnt_reg <= '0;
            else if (state_reg == READ)  rd_cnt_reg <= rd_cnt_reg + 1'b1;
            flush_cnt_reg <= (state_reg == FLUSH) ? flush_cnt_reg + 2'd1 : 2'd0;
            rd_valid_reg  <= (state_reg == READ);
        end
    end

    // Window validity and row index: the first shift only primes the window,
    // every later shift presents the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_reg    <= 1'b0;
            valid_set_reg <= 1'b0;
            calc_row_reg  <= '0;
        end else if (start_pass) begin
            primed_reg    <= 1'b0;
            valid_set_reg <= 1'b0;
        end else if (shift_en || shift_zero) begin
            if (primed_reg) begin
                valid_set_reg <= 1'b1;
                calc_row_reg  <= valid_set_reg ? calc_row_reg + 1'b1 : '0;
            end else begin
                primed_reg    <= 1'b1;
            end
        end else begin
            valid_set_reg <= 1'b0;
        end
    end

    // Pass status flags and the completed-generation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg      <= 1'b0;
            calc_flg_reg  <= 1'b0;
            done_reg      <= 1'b0;
            gen_count_reg <= '0;
        end else begin
            if (start_pass) begin
                busy_reg     <= 1'b1;
                calc_flg_reg <= 1'b1;
            end else if (enter_done) begin
                busy_reg     <= 1'b0;
                calc_flg_reg <= 1'b0;
            end
            done_reg <= enter_done;
            if (enter_done) gen_count_reg <= gen_count_reg + 16'd1;
        end
    end

    row_window_shift #(
        .ROW_LENGTH (ROW_LENGTH)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_pass),
        .shift_en   (shift_en),
        .shift_zero (shift_zero),
        .din        (rd_data),
        .top_row    (top_row),
        .middle_row (middle_row),
        .bottom_row (bottom_row)
    );

    assign rd_en       = (state_reg == READ);
    assign rd_addr     = rd_cnt_reg;
    assign calc_row_in = calc_row_reg;
    assign calc_flg    = calc_flg_reg;
    assign valid_set   = valid_set_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign gen_count   = gen_count_reg;

endmodule
